// File: rtl/shift_acc_mc_pkg.sv
// rtl/shift_acc_mc_pkg.sv - shared types and helpers for shift_acc_mc
package shift_acc_mc_pkg;

  typedef enum logic [1:0] {ACC, FLUSH, DRAIN} state_t;

  function automatic int clogb2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Result word layout: {ovf, ch, acc} with acc in the low bits
  function automatic int ch_lsb(input int acc_w);
    return acc_w;
  endfunction

  function automatic int ovf_pos(input int ch_w, input int acc_w);
    return ch_w + acc_w;
  endfunction

  // {overflowed, true sign} of an (ACC_W+1)-bit sum, from its two top bits
  function automatic logic [1:0] sum_ovf(input logic top, input logic next);
    return {top ^ next, top};
  endfunction

  function automatic logic sat_sel(input logic sat_mode, input logic ovf);
    return sat_mode & ovf;
  endfunction

endpackage

// File: rtl/shift_acc_mc_shifter.sv
// rtl/shift_acc_mc_shifter.sv - stage 1: exact left shift, shift overflow, clamp
module shift_acc_mc_shifter
  import shift_acc_mc_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SHIFT_W = 7,
  parameter int ACC_W   = 128,
  parameter int NUM_CH  = 32,
  parameter int CH_IN_W = 8,
  parameter int SAT     = 0,
  localparam int CH_W   = clogb2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_tdata,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_sign,
  input  logic [CH_IN_W-1:0] in_ch,
  output logic               s1_valid,
  output logic [ACC_W-1:0]   s1_mag,
  output logic               s1_sign,
  output logic [CH_W-1:0]    s1_ch,
  output logic               s1_shift_ovf,
  output logic               s1_drop
);

  localparam int EXT_W  = DATA_W + (1 << SHIFT_W) - 1;
  localparam int WIDE_W = (EXT_W > ACC_W) ? EXT_W : ACC_W;
  localparam logic [ACC_W-1:0]   ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [CH_IN_W:0]   NUM_CH_L = (CH_IN_W+1)'(NUM_CH);

  logic [WIDE_W-1:0] wide;
  logic [ACC_W-1:0]  mag;
  logic              shift_ovf;
  logic              drop;

  always_comb begin
    wide      = WIDE_W'(in_tdata) << in_shift;
    // anything at or above the sign bit exceeds the positive accumulator range
    shift_ovf = |wide[WIDE_W-1:ACC_W-1];
    mag       = wide[ACC_W-1:0];
    if (sat_sel(SAT != 0, shift_ovf)) mag = ACC_MAX;
    drop      = ({1'b0, in_ch} >= NUM_CH_L);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_mag       <= '0;
      s1_sign      <= 1'b0;
      s1_ch        <= '0;
      s1_shift_ovf <= 1'b0;
      s1_drop      <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mag       <= mag;
        s1_sign      <= in_sign;
        s1_ch        <= in_ch[CH_W-1:0];
        s1_shift_ovf <= shift_ovf;
        s1_drop      <= drop;
      end
    end
  end

endmodule

// File: rtl/shift_acc_mc.sv
// rtl/shift_acc_mc.sv - multi-channel shift-and-accumulate engine with drain/clear
module shift_acc_mc
  import shift_acc_mc_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int SHIFT_W = 7,
  parameter int ACC_W   = 128,
  parameter int NUM_CH  = 32,
  parameter int CH_IN_W = 8,
  parameter int SAT     = 0,
  localparam int CH_W   = clogb2(NUM_CH),
  localparam int OUT_W  = 1 + CH_W + ACC_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_tvalid,
  output logic               in_tready,
  input  logic [DATA_W-1:0]  in_tdata,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic               in_sign,
  input  logic [CH_IN_W-1:0] in_ch,
  input  logic               clr_valid,
  output logic               clr_ready,
  output logic               out_tvalid,
  input  logic               out_tready,
  output logic [OUT_W-1:0]   out_tdata,
  output logic               err_ch_drop
);

  localparam int OVF_POS = ovf_pos(CH_W, ACC_W);
  localparam int CH_LSB  = ch_lsb(ACC_W);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);

  state_t state_q, state_d;
  logic   rdy_q;
  logic [CH_W-1:0] idx_q;

  logic              s1_valid, s1_sign, s1_shift_ovf, s1_drop;
  logic [ACC_W-1:0]  s1_mag;
  logic [CH_W-1:0]   s1_ch;

  logic [ACC_W-1:0]  acc_q [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;
  logic [ACC_W-1:0]  acc_cur, acc_nxt;
  logic [ACC_W:0]    sum;
  logic [1:0]        sovf;
  logic              wr_en, drain_hs;

  shift_acc_mc_shifter #(
    .DATA_W(DATA_W), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W),
    .NUM_CH(NUM_CH), .CH_IN_W(CH_IN_W), .SAT(SAT)
  ) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_tvalid & in_tready),
    .in_tdata     (in_tdata),
    .in_shift     (in_shift),
    .in_sign      (in_sign),
    .in_ch        (in_ch),
    .s1_valid     (s1_valid),
    .s1_mag       (s1_mag),
    .s1_sign      (s1_sign),
    .s1_ch        (s1_ch),
    .s1_shift_ovf (s1_shift_ovf),
    .s1_drop      (s1_drop)
  );

  always_comb begin
    acc_cur = acc_q[s1_ch];
    if (s1_sign) sum = {acc_cur[ACC_W-1], acc_cur} - {1'b0, s1_mag};
    else         sum = {acc_cur[ACC_W-1], acc_cur} + {1'b0, s1_mag};
    sovf    = sum_ovf(sum[ACC_W], sum[ACC_W-1]);
    acc_nxt = sum[ACC_W-1:0];
    if (sat_sel(SAT != 0, sovf[1])) acc_nxt = sovf[0] ? ACC_MIN : ACC_MAX;
    wr_en    = s1_valid & ~s1_drop;
    drain_hs = out_tvalid & out_tready;
  end

  always_comb begin
    state_d    = state_q;
    in_tready  = 1'b0;
    clr_ready  = 1'b0;
    out_tvalid = 1'b0;
    unique case (state_q)
      ACC: begin
        // readies held low during reset and for the cycle it is released
        in_tready = rdy_q & ~rst;
        clr_ready = rdy_q & ~rst;
        if (clr_valid && clr_ready) state_d = FLUSH;
      end
      FLUSH: if (!s1_valid) state_d = DRAIN;
      DRAIN: begin
        out_tvalid = 1'b1;
        if (out_tready && idx_q == LAST_CH) state_d = ACC;
      end
      default: state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACC;
      rdy_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (state_q != DRAIN) idx_q <= '0;
      else if (out_tready)  idx_q <= idx_q + 1'b1;
    end
  end

  // Stage 2 read-modify-write; the drain never overlaps it since FLUSH empties the pipe
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) acc_q[i] <= '0;
      ovf_q       <= '0;
      err_ch_drop <= 1'b0;
    end else begin
      err_ch_drop <= s1_valid & s1_drop;
      if (wr_en) begin
        acc_q[s1_ch] <= acc_nxt;
        ovf_q[s1_ch] <= ovf_q[s1_ch] | s1_shift_ovf | sovf[1];
      end
      if (drain_hs) begin
        acc_q[idx_q] <= '0;
        ovf_q[idx_q] <= 1'b0;
      end
    end
  end

  always_comb begin
    out_tdata                     = '0;
    out_tdata[OVF_POS]            = ovf_q[idx_q];
    out_tdata[CH_LSB +: CH_W]     = idx_q;
    out_tdata[ACC_W-1:0]          = acc_q[idx_q];
  end

endmodule

// File: tb/tb_shift_acc_mc.sv
// tb/tb_shift_acc_mc.sv - scoreboard bench for shift_acc_mc
module tb_shift_acc_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_tvalid, in_tready, in_sign, clr_valid, clr_ready;
  logic         out_tvalid, out_tready, err_ch_drop;
  logic [63:0]  in_tdata;
  logic [6:0]   in_shift;
  logic [7:0]   in_ch;
  logic [133:0] out_tdata;

  logic         s_in_tvalid, s_in_sign, s_clr_valid, s_out_tready;
  logic [15:0]  s_in_tdata;
  logic [3:0]   s_in_shift;
  logic [7:0]   s_in_ch;
  logic         sat_in_tready, sat_clr_ready, sat_out_tvalid, sat_err;
  logic         wrap_in_tready, wrap_clr_ready, wrap_out_tvalid, wrap_err;
  logic [18:0]  sat_out_tdata, wrap_out_tdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic signed [127:0] m_acc [32];
  logic                m_ovf [32];
  logic [133:0]        sb [$];

  shift_acc_mc u_dut (
    .clk(clk), .rst(rst),
    .in_tvalid(in_tvalid), .in_tready(in_tready), .in_tdata(in_tdata),
    .in_shift(in_shift), .in_sign(in_sign), .in_ch(in_ch),
    .clr_valid(clr_valid), .clr_ready(clr_ready),
    .out_tvalid(out_tvalid), .out_tready(out_tready), .out_tdata(out_tdata),
    .err_ch_drop(err_ch_drop)
  );

  shift_acc_mc #(.DATA_W(16), .SHIFT_W(4), .ACC_W(16), .NUM_CH(4), .CH_IN_W(8), .SAT(1)) u_sat (
    .clk(clk), .rst(rst),
    .in_tvalid(s_in_tvalid), .in_tready(sat_in_tready), .in_tdata(s_in_tdata),
    .in_shift(s_in_shift), .in_sign(s_in_sign), .in_ch(s_in_ch),
    .clr_valid(s_clr_valid), .clr_ready(sat_clr_ready),
    .out_tvalid(sat_out_tvalid), .out_tready(s_out_tready), .out_tdata(sat_out_tdata),
    .err_ch_drop(sat_err)
  );

  shift_acc_mc #(.DATA_W(16), .SHIFT_W(4), .ACC_W(16), .NUM_CH(4), .CH_IN_W(8), .SAT(0)) u_wrap (
    .clk(clk), .rst(rst),
    .in_tvalid(s_in_tvalid), .in_tready(wrap_in_tready), .in_tdata(s_in_tdata),
    .in_shift(s_in_shift), .in_sign(s_in_sign), .in_ch(s_in_ch),
    .clr_valid(s_clr_valid), .clr_ready(wrap_clr_ready),
    .out_tvalid(wrap_out_tvalid), .out_tready(s_out_tready), .out_tdata(wrap_out_tdata),
    .err_ch_drop(wrap_err)
  );

  // Reference: exact signed arithmetic, flag when the shifted value or the sum leaves range
  task automatic model_beat(input logic [63:0] d, input logic [6:0] s, input logic sg, input logic [7:0] c);
    logic signed [255:0] w, sx, maxw, minw;
    if (c >= 8'd32) return;
    maxw = (256'sd1 <<< 127) - 256'sd1;
    minw = -maxw - 256'sd1;
    w    = $signed({192'd0, d}) <<< s;
    sx   = m_acc[c];
    sx   = sg ? sx - w : sx + w;
    if (w > maxw || sx > maxw || sx < minw) m_ovf[c] = 1'b1;
    m_acc[c] = sx[127:0];
  endtask

  function automatic void push_all();
    for (int c = 0; c < 32; c++) begin
      sb.push_back({m_ovf[c], 5'(c), m_acc[c]});
      m_acc[c] = '0;
      m_ovf[c] = 1'b0;
    end
  endfunction

  task automatic send_beat(input logic [63:0] d, input logic [6:0] s, input logic sg, input logic [7:0] c);
    int k = 0;
    in_tvalid = 1'b1; in_tdata = d; in_shift = s; in_sign = sg; in_ch = c;
    while (in_tready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    if (in_tready !== 1'b1) begin
      n_fail++; $display("FAIL beat_accept: in_tready=%b required 1", in_tready);
    end else model_beat(d, s, sg, c);
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr_valid = 1'b1;
    n_tests++;
    if (clr_ready !== 1'b1) begin
      n_fail++; $display("FAIL clr_immediate: clr_ready=%b required 1", clr_ready);
    end
    push_all();
    @(negedge clk);
    clr_valid = 1'b0;
  endtask

  // mode 0: out_tready held high; mode 1: random backpressure
  task automatic drain(input int mode, input int stop_after);
    int k = 0, got = 0, cyc = 0;
    logic stalled = 1'b0;
    logic [133:0] held = '0, exp;
    while (out_tvalid !== 1'b1 && k < 6) begin @(negedge clk); k++; end
    n_tests++;
    if (out_tvalid !== 1'b1 || k > 3) begin
      n_fail++; $display("FAIL first_result_latency: waited=%0d valid=%b required <=3 and 1", k, out_tvalid);
    end
    while (got < stop_after && cyc < 400) begin
      out_tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      n_tests++;
      if (in_tready !== 1'b0 || clr_ready !== 1'b0) begin
        n_fail++; $display("FAIL ready_in_drain: in_tready=%b clr_ready=%b required 0 0", in_tready, clr_ready);
      end
      if (stalled) begin
        n_tests++;
        if (out_tvalid !== 1'b1 || out_tdata !== held) begin
          n_fail++; $display("FAIL stall_stable: valid=%b data=%h required 1 %h", out_tvalid, out_tdata, held);
        end
      end
      if (out_tvalid === 1'b1 && out_tready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL sb_empty: got beat %h with no expectation", out_tdata);
        end else begin
          exp = sb.pop_front();
          if (out_tdata !== exp) begin
            n_fail++; $display("FAIL drain_beat%0d: got %h required %h", got, out_tdata, exp);
          end
        end
        got++;
        stalled = 1'b0;
      end else begin
        stalled = (out_tvalid === 1'b1);
        held    = out_tdata;
      end
      @(negedge clk);
      cyc++;
    end
    out_tready = 1'b0;
    n_tests++;
    if (got != stop_after) begin
      n_fail++; $display("FAIL drain_count: got %0d beats required %0d", got, stop_after);
    end
    if (stop_after == 32) begin
      n_tests++;
      if (in_tready !== 1'b1 || out_tvalid !== 1'b0) begin
        n_fail++; $display("FAIL back_to_acc: in_tready=%b out_tvalid=%b required 1 0", in_tready, out_tvalid);
      end
      if (mode == 0) begin
        n_tests++;
        if (cyc != 32) begin
          n_fail++; $display("FAIL drain_cycles: took %0d required 32", cyc);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_tests++;
    if (out_tvalid !== 1'b0 || err_ch_drop !== 1'b0 || in_tready !== 1'b0 || clr_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs: tv=%b err=%b ir=%b cr=%b required 0 0 0 0",
                         out_tvalid, err_ch_drop, in_tready, clr_ready);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_tready !== 1'b0) begin
      n_fail++; $display("FAIL ready_release_same_cycle: in_tready=%b required 0", in_tready);
    end
    @(negedge clk);
    n_tests++;
    if (in_tready !== 1'b1 || clr_ready !== 1'b1 || sat_in_tready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_reset: ir=%b cr=%b sat_ir=%b required 1 1 1",
                         in_tready, clr_ready, sat_in_tready);
    end
  endtask

  task automatic test_single_add_sub();
    send_beat(64'd5, 7'd4, 1'b0, 8'd3);
    send_beat(64'd16, 7'd0, 1'b1, 8'd3);
    in_tvalid = 1'b0;
    do_clear();
    drain(0, 32);
  endtask

  task automatic test_back_to_back();
    int drops = 0;
    for (int i = 0; i < 99; i++) begin
      if (in_tready !== 1'b1) drops++;
      send_beat(64'd1, 7'd0, 1'b0, 8'd7);
    end
    // final beat accepted together with the clear must land in the drain
    in_tdata = 64'd1; in_shift = 7'd0; in_sign = 1'b0; in_ch = 8'd7;
    in_tvalid = 1'b1;
    clr_valid = 1'b1;
    n_tests++;
    if (drops != 0 || in_tready !== 1'b1 || clr_ready !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ready: drops=%0d ir=%b cr=%b required 0 1 1", drops, in_tready, clr_ready);
    end
    model_beat(64'd1, 7'd0, 1'b0, 8'd7);
    push_all();
    @(negedge clk);
    in_tvalid = 1'b0;
    clr_valid = 1'b0;
    drain(0, 32);
  endtask

  task automatic test_ovf_backpressure();
    send_beat(64'd1, 7'd127, 1'b0, 8'd5);
    send_beat(64'd3, 7'd2, 1'b1, 8'd6);
    send_beat(64'hFFFF_FFFF_FFFF_FFFF, 7'd60, 1'b0, 8'd31);
    in_tvalid = 1'b0;
    do_clear();
    drain(1, 32);
  endtask

  task automatic test_invalid_ch();
    in_tdata = 64'd9; in_shift = 7'd1; in_sign = 1'b0; in_ch = 8'd40;
    in_tvalid = 1'b1;
    n_tests++;
    if (in_tready !== 1'b1) begin
      n_fail++; $display("FAIL drop_accept: in_tready=%b required 1", in_tready);
    end
    @(negedge clk);
    in_tvalid = 1'b0;
    n_tests++;
    if (err_ch_drop !== 1'b0) begin
      n_fail++; $display("FAIL drop_early: err_ch_drop=%b required 0", err_ch_drop);
    end
    @(negedge clk);
    n_tests++;
    if (err_ch_drop !== 1'b1) begin
      n_fail++; $display("FAIL drop_pulse: err_ch_drop=%b required 1", err_ch_drop);
    end
    @(negedge clk);
    n_tests++;
    if (err_ch_drop !== 1'b0) begin
      n_fail++; $display("FAIL drop_one_cycle: err_ch_drop=%b required 0", err_ch_drop);
    end
    do_clear();
    drain(0, 32);
  endtask

  task automatic test_reset_mid_drain();
    send_beat(64'd9, 7'd0, 1'b0, 8'd20);
    send_beat(64'd1, 7'd100, 1'b0, 8'd31);
    in_tvalid = 1'b0;
    do_clear();
    drain(1, 10);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_tvalid !== 1'b0 || in_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_abort: out_tvalid=%b in_tready=%b required 0 0", out_tvalid, in_tready);
    end
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    do_clear();
    drain(0, 32);
  endtask

  task automatic test_sat_wrap();
    logic [18:0] e_sat, e_wrap;
    int k = 0;
    s_in_tdata = 16'h7FFF; s_in_shift = 4'd0; s_in_sign = 1'b0; s_in_ch = 8'd0;
    s_in_tvalid = 1'b1;
    repeat (2) begin
      n_tests++;
      if (sat_in_tready !== 1'b1 || wrap_in_tready !== 1'b1) begin
        n_fail++; $display("FAIL sat_accept: sat=%b wrap=%b required 1 1", sat_in_tready, wrap_in_tready);
      end
      @(negedge clk);
    end
    s_in_tvalid = 1'b0;
    s_clr_valid = 1'b1;
    @(negedge clk);
    s_clr_valid = 1'b0;
    while (sat_out_tvalid !== 1'b1 && k < 6) begin @(negedge clk); k++; end
    for (int c = 0; c < 4; c++) begin
      s_out_tready = 1'b1;
      e_sat  = (c == 0) ? {1'b1, 2'd0, 16'h7FFF} : {1'b0, 2'(c), 16'h0000};
      e_wrap = (c == 0) ? {1'b1, 2'd0, 16'hFFFE} : {1'b0, 2'(c), 16'h0000};
      n_tests++;
      if (sat_out_tvalid !== 1'b1 || sat_out_tdata !== e_sat) begin
        n_fail++; $display("FAIL sat_ch%0d: valid=%b data=%h required 1 %h", c, sat_out_tvalid, sat_out_tdata, e_sat);
      end
      n_tests++;
      if (wrap_out_tvalid !== 1'b1 || wrap_out_tdata !== e_wrap) begin
        n_fail++; $display("FAIL wrap_ch%0d: valid=%b data=%h required 1 %h", c, wrap_out_tvalid, wrap_out_tdata, e_wrap);
      end
      @(negedge clk);
    end
    s_out_tready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_tvalid = 1'b0; in_tdata = '0; in_shift = '0; in_sign = 1'b0; in_ch = '0;
    clr_valid = 1'b0; out_tready = 1'b0;
    s_in_tvalid = 1'b0; s_in_tdata = '0; s_in_shift = '0; s_in_sign = 1'b0; s_in_ch = '0;
    s_clr_valid = 1'b0; s_out_tready = 1'b0;
    for (int c = 0; c < 32; c++) begin m_acc[c] = '0; m_ovf[c] = 1'b0; end
    test_reset();
    test_single_add_sub();
    test_back_to_back();
    test_ovf_backpressure();
    test_invalid_ch();
    test_reset_mid_drain();
    test_sat_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
